// File: rtl/uart_rx_loader.sv
// Host command decoder behind the UART receiver: loads 32-bit words into
// instruction memory or pulses run/step, with an inter-byte timeout.
module uart_rx_loader #(
  parameter int unsigned ADDR_W        = 10,
  parameter int unsigned TIMEOUT_TICKS = 4096,
  parameter logic [7:0]  CMD_LOAD      = 8'h01,
  parameter logic [7:0]  CMD_RUN       = 8'h02,
  parameter logic [7:0]  CMD_STEP      = 8'h03
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_tick,
  input  logic              rx_done_tick,
  input  logic [7:0]        din,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              load_done,
  output logic              run_pulse,
  output logic              step_pulse,
  output logic              err_pulse,
  output logic              busy
);

  localparam int unsigned TICK_W = $clog2(TIMEOUT_TICKS + 1);

  typedef enum logic [1:0] {IDLE, CNT_LO, CNT_HI, DATA} state_e;

  state_e              state_q, state_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          idx_q, idx_d;
  logic [31:0]         word_q, word_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                load_done_q, load_done_d;
  logic                run_q, run_d;
  logic                step_q, step_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic                timeout_c;

  // A byte arriving on the expiring tick wins over the timeout.
  assign timeout_c = (state_q != IDLE) && s_tick && !rx_done_tick &&
                     (tick_q == TICK_W'(TIMEOUT_TICKS - 1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    idx_d       = idx_q;
    word_d      = word_q;
    tick_d      = tick_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    load_done_d = 1'b0;
    run_d       = 1'b0;
    step_d      = 1'b0;
    err_d       = 1'b0;

    if (state_q != IDLE && s_tick) tick_d = tick_q + TICK_W'(1);
    if (rx_done_tick)              tick_d = '0;

    case (state_q)
      IDLE: begin
        if (rx_done_tick) begin
          if (din == CMD_LOAD)      state_d = CNT_LO;
          else if (din == CMD_RUN)  run_d   = 1'b1;
          else if (din == CMD_STEP) step_d  = 1'b1;
          else                      err_d   = 1'b1;
        end
      end
      CNT_LO: begin
        if (rx_done_tick) begin
          cnt_d   = {cnt_q[15:8], din};
          state_d = CNT_HI;
        end
      end
      CNT_HI: begin
        if (rx_done_tick) begin
          cnt_d = {din, cnt_q[7:0]};
          if ({din, cnt_q[7:0]} == 16'd0) begin
            load_done_d = 1'b1;
            state_d     = IDLE;
          end else begin
            addr_d  = '0;
            idx_d   = 2'd0;
            word_d  = '0;
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (rx_done_tick) begin
          // Little-endian: each new byte enters at the top and shifts down.
          word_d = {din, word_q[31:8]};
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = addr_q;
            mem_wdata_d = {din, word_q[31:8]};
            addr_d      = addr_q + ADDR_W'(1);
            cnt_d       = cnt_q - 16'd1;
            if (cnt_q == 16'd1) begin
              load_done_d = 1'b1;
              state_d     = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (timeout_c) begin
      err_d   = 1'b1;
      state_d = IDLE;
      idx_d   = 2'd0;
      word_d  = '0;
    end

    if (state_d == IDLE) tick_d = '0;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      idx_q       <= '0;
      word_q      <= '0;
      tick_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      load_done_q <= 1'b0;
      run_q       <= 1'b0;
      step_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      idx_q       <= idx_d;
      word_q      <= word_d;
      tick_q      <= tick_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      load_done_q <= load_done_d;
      run_q       <= run_d;
      step_q      <= step_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign load_done  = load_done_q;
  assign run_pulse  = run_q;
  assign step_pulse = step_q;
  assign err_pulse  = err_q;
  assign busy       = busy_q;

endmodule

// File: doc/uart_rx_loader.md
Name: uart_rx_loader

Overview:
- Sits directly downstream of the UART receiver.
- Consumes its byte stream (done strobe plus data byte) and decodes a simple host command protocol.
- Command set: load 32-bit words into the pipeline's instruction memory, or pulse run/step controls to the processor debug logic.
- Uses the same oversampling tick as the receiver to enforce an inter-byte timeout so a truncated transfer cannot hang the loader.

Parameters:
ADDR_W, 10, word-address width of the instruction memory write port
TIMEOUT_TICKS, 4096, s_tick count without a received byte, while mid-command, that aborts the command
CMD_LOAD, 8'h01, command byte: load words
CMD_RUN, 8'h02, command byte: pulse run
CMD_STEP, 8'h03, command byte: pulse step

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
s_tick  in  1  baud oversampling tick (16x), one clk wide
rx_done_tick  in  1  one-cycle strobe: din holds a new received byte
din  in  8  received byte, valid when rx_done_tick=1
mem_we  out  1  instruction memory write enable, one-cycle pulse
mem_addr  out  ADDR_W  word address for mem_we
mem_wdata  out  32  word data for mem_we
load_done  out  1  one-cycle pulse: load command completed
run_pulse  out  1  one-cycle pulse: run command
step_pulse  out  1  one-cycle pulse: step command
err_pulse  out  1  one-cycle pulse: unknown command or timeout
busy  out  1  1 whenever state != IDLE

Behaviour:
- All outputs are registered. While reset=0, every output is 0, state=IDLE, and all counters, the address and the word shift register are cleared. Reset takes effect asynchronously, including mid-transfer; a partial word is discarded.
- States: IDLE, CNT_LO, CNT_HI, DATA.
- IDLE, on rx_done_tick:
  - din==CMD_LOAD -> CNT_LO.
  - din==CMD_RUN -> run_pulse=1 next cycle; stay IDLE.
  - din==CMD_STEP -> step_pulse=1 next cycle; stay IDLE.
  - any other value -> err_pulse=1 next cycle; stay IDLE.
- CNT_LO, on byte: word_cnt[7:0]=din -> CNT_HI.
- CNT_HI, on byte: word_cnt[15:8]=din.
  - If the full count is 0: load_done=1 next cycle -> IDLE.
  - Otherwise: clear the write address and byte index -> DATA.
- DATA: bytes are little-endian; the first byte after the count is bits [7:0] of word 0.
  - A 2-bit byte index counts bytes within the word.
  - On the 4th byte, the next cycle drives mem_we=1, mem_wdata=assembled word and mem_addr=current address (first word at address 0). The address then increments and the word counter decrements.
  - Latency: mem_we rises exactly 1 clk after the rx_done_tick of the word's last byte.
  - After the last word, load_done=1 in the same cycle as the final mem_we, then -> IDLE.
  - The address wraps modulo 2^ADDR_W. Counts larger than the memory overwrite from address 0; this is not an error.
- Timeout:
  - The tick counter clears on every rx_done_tick and on entry to IDLE.
  - Outside IDLE it increments on each s_tick.
  - On reaching TIMEOUT_TICKS: err_pulse=1 next cycle, state -> IDLE, partial word discarded. Words already written remain in memory.
  - The counter is inactive in IDLE.
- Simultaneous rx_done_tick and the timeout-reaching s_tick in the same cycle: the byte is accepted and the timeout is not taken.
- Only one output pulse source fires per cycle. mem_we and load_done coincide only on the final word.
- run/step bytes received during CNT_LO/CNT_HI/DATA are treated as data, never as commands.
- busy=1 from the cycle after a CMD_LOAD byte until the cycle load_done or err_pulse is asserted. In that terminal cycle busy=0.

Test Plan:
- Reset held low mid-load, released -> all outputs 0, busy=0; a following 0x02 byte gives run_pulse exactly 1 clk after its rx_done_tick.
- Bytes 01 02 00 | 78 56 34 12 | EF BE AD DE -> mem_we at addr 0 with 0x12345678, then addr 1 with 0xDEADBEEF; load_done coincides with the second mem_we; each mem_we is 1 clk after its 4th byte.
- Bytes 01 00 00 -> no mem_we; load_done 1 clk after the third byte; busy returns to 0.
- Byte 0x7F in IDLE -> err_pulse once, no other output; 0x03 then gives step_pulse.
- 01 01 00 AA BB, then no bytes for 4096 s_ticks -> err_pulse, busy=0, no mem_we; a subsequent full load starts at address 0. With the 4096th s_tick coincident with an rx_done_tick -> no error.
- ADDR_W=2, count 5 -> writes to addresses 0,1,2,3,0; load_done on the 5th write.
